// File: rtl/aes_afu_pkg.sv
// Shared types and register map for the AES-CTR AFU CSR read/write paths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_afu_pkg;

    localparam int MMIO_TID_W = 9;
    typedef logic [MMIO_TID_W-1:0] t_mmio_tid;

    // Only these two encodings are legal on the MMIO length field
    typedef enum logic [1:0] {
        LEN_4B = 2'd0,
        LEN_8B = 2'd1
    } t_mmio_len;

    // CSR index within the app window (dword offset / 2)
    typedef logic [7:0] t_csr_idx;

    localparam t_csr_idx CSR_STATUS      = 8'd0;
    localparam t_csr_idx CSR_SRC_ADDR    = 8'd1;
    localparam t_csr_idx CSR_DEST_ADDR   = 8'd2;
    localparam t_csr_idx CSR_DATA_LENGTH = 8'd3;
    localparam t_csr_idx CSR_IV_0        = 8'd4;
    localparam t_csr_idx CSR_IV_1        = 8'd5;
    localparam t_csr_idx CSR_KEY_0       = 8'd6;
    localparam t_csr_idx CSR_KEY_3       = 8'd9;
    localparam t_csr_idx CSR_CYC_CNT     = 8'd10;
    localparam t_csr_idx CSR_RD_LINES    = 8'd11;
    localparam t_csr_idx CSR_WR_LINES    = 8'd12;
    localparam t_csr_idx CSR_RUNS_DONE   = 8'd13;

    // Status register bit positions
    localparam int STAT_IDLE_BIT    = 0;
    localparam int STAT_ILLEGAL_BIT = 1;

    function automatic logic len_is_legal(input logic [1:0] len);
        return (len == LEN_4B) || (len == LEN_8B);
    endfunction

endpackage

// File: rtl/aes_perf_counter.sv
// 64-bit wrapping event counter; clear wins over increment.
// Latency: new value visible the cycle after clr/inc.
// Backpressure: none, counts every qualifying cycle.
module aes_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [63:0] cnt
);

    // Clear has priority over increment; wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

endmodule

// File: rtl/aes_csr_rd_responder.sv
// MMIO read responder: config readback, run status and per-run perf counters.
// Latency: fixed 2 cycles from mmio_rd_valid to rsp_valid, one request per cycle.
// Backpressure: none; every request is answered in order, in-flight reads dropped on reset.
module aes_csr_rd_responder
    import aes_afu_pkg::*;
#(
    parameter logic [15:0] CSR_BASE_DW = 16'h0020,
    parameter int          NUM_RD_CSRS = 12,
    parameter int          TID_W       = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mmio_rd_valid,
    input  logic [15:0]      mmio_rd_addr,
    input  logic [1:0]       mmio_rd_len,
    input  logic [TID_W-1:0] mmio_rd_tid,
    output logic             rsp_valid,
    output logic [TID_W-1:0] rsp_tid,
    output logic [63:0]      rsp_data,
    input  logic [63:0]      cfg_src_addr,
    input  logic [63:0]      cfg_dest_addr,
    input  logic [63:0]      cfg_data_length,
    input  logic [63:0]      cfg_iv_0,
    input  logic [63:0]      cfg_iv_1,
    input  logic             run_pulse,
    input  logic             afu_busy,
    input  logic             afu_done_pulse,
    input  logic             rd_line_evt,
    input  logic             wr_line_evt
);

    // Window spans two dwords per CSR; ext counters only exist in larger builds
    localparam logic [15:0] WIN_DW  = 16'(2 * NUM_RD_CSRS);
    localparam bit          MAP_EXT = (NUM_RD_CSRS >= 14);

    logic [63:0] cyc_cnt, rd_lines, wr_lines, runs_done;

    aes_perf_counter u_cyc_cnt   (.clk(clk), .reset(reset), .clr(run_pulse), .inc(afu_busy),       .cnt(cyc_cnt));
    aes_perf_counter u_rd_lines  (.clk(clk), .reset(reset), .clr(run_pulse), .inc(rd_line_evt),    .cnt(rd_lines));
    aes_perf_counter u_wr_lines  (.clk(clk), .reset(reset), .clr(run_pulse), .inc(wr_line_evt),    .cnt(wr_lines));
    aes_perf_counter u_runs_done (.clk(clk), .reset(reset), .clr(1'b0),      .inc(afu_done_pulse), .cnt(runs_done));

    logic             ill_flag;
    logic [15:0]      rd_off;
    logic             in_win;
    t_csr_idx         rd_idx;
    logic [63:0]      status_val;
    logic [63:0]      sel_val;

    logic             s1_vld;
    logic [TID_W-1:0] s1_tid;
    logic [1:0]       s1_len;
    logic             s1_odd;
    logic [63:0]      s1_val;
    logic [63:0]      fmt_data;

    assign rd_off = mmio_rd_addr - CSR_BASE_DW;
    assign in_win = (mmio_rd_addr >= CSR_BASE_DW) && (rd_off < WIN_DW);
    assign rd_idx = rd_off[8:1];

    // Status word built from live busy and the sticky illegal-length flag
    always_comb begin
        status_val                   = '0;
        status_val[STAT_IDLE_BIT]    = !afu_busy;
        status_val[STAT_ILLEGAL_BIT] = ill_flag;
    end

    // Select the addressed CSR from current-cycle state (pre-update snapshot)
    always_comb begin
        sel_val = '0;
        if (in_win) begin
            case (rd_idx)
                CSR_STATUS:      sel_val = status_val;
                CSR_SRC_ADDR:    sel_val = cfg_src_addr;
                CSR_DEST_ADDR:   sel_val = cfg_dest_addr;
                CSR_DATA_LENGTH: sel_val = cfg_data_length;
                CSR_IV_0:        sel_val = cfg_iv_0;
                CSR_IV_1:        sel_val = cfg_iv_1;
                CSR_CYC_CNT:     sel_val = cyc_cnt;
                CSR_RD_LINES:    sel_val = rd_lines;
                CSR_WR_LINES:    sel_val = MAP_EXT ? wr_lines  : 64'd0;
                CSR_RUNS_DONE:   sel_val = MAP_EXT ? runs_done : 64'd0;
                // Key slots are write-only and read back as zero
                default:         sel_val = '0;
            endcase
        end
    end

    // Stage 1: capture request fields and the value snapshot; latch illegal lengths
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_tid   <= '0;
            s1_len   <= '0;
            s1_odd   <= 1'b0;
            s1_val   <= '0;
            ill_flag <= 1'b0;
        end else begin
            s1_vld <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                s1_tid <= mmio_rd_tid;
                s1_len <= mmio_rd_len;
                s1_odd <= rd_off[0];
                s1_val <= sel_val;
                if (!len_is_legal(mmio_rd_len)) begin
                    ill_flag <= 1'b1;
                end
            end
        end
    end

    // Shape the snapshot to the requested width; odd 8 B reads use the even dword below
    always_comb begin
        fmt_data = '0;
        if (s1_len == LEN_8B) begin
            fmt_data = s1_val;
        end else if (s1_len == LEN_4B) begin
            fmt_data = s1_odd ? {32'h0, s1_val[63:32]} : {32'h0, s1_val[31:0]};
        end
    end

    // Stage 2: drive the response; tid/data hold when no response is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_vld;
            if (s1_vld) begin
                rsp_tid  <= s1_tid;
                rsp_data <= fmt_data;
            end
        end
    end

endmodule
